// File: rtl/mdu_pkg.sv
// Purpose: shared HI/LO multiply-divide opcode encodings and default timing.
// Latency: n/a (declarations only).
// Backpressure: n/a; the decoder and the MDU both import these encodings.
package mdu_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MFHI  = 4'd4,
        OP_MFLO  = 4'd5,
        OP_MTHI  = 4'd6,
        OP_MTLO  = 4'd7,
        OP_NONE  = 4'd15
    } md_op_e;

    // Opcodes that launch a multi-cycle operation.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Purpose: MIPS-style HI/LO multiply/divide unit with mfhi/mflo/mthi/mtlo access.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES; HI/LO written on the last edge.
// Backpressure: busy=1 while running; start and mthi/mtlo are ignored until busy drops.
// Ports: clk, rst_n (async active-low); start/op/a/b from the E stage;
//        busy status, out = mfhi/mflo read data, hi/lo = committed registers.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [3:0]         op_q;

    // Result datapath, driven only by the captured operands.
    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        div_ovf;
    logic [31:0] sdiv_by;
    logic [31:0] udiv_by;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        res_wr;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        // Divisors are steered away from zero (result discarded anyway) and,
        // for the signed overflow case, to 1 so that a/1 yields 0x80000000 rem 0.
        div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        sdiv_by = ((b_q == 32'd0) || div_ovf) ? 32'd1 : b_q;
        udiv_by = (b_q == 32'd0) ? 32'd1 : b_q;
        quo_s   = $signed(a_q) / $signed(sdiv_by);
        rem_s   = $signed(a_q) % $signed(sdiv_by);
        quo_u   = a_q / udiv_by;
        rem_u   = a_q % udiv_by;

        res_wr = 1'b0;
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op_q)
            OP_MULT: begin
                res_wr = 1'b1;
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_wr = 1'b1;
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_wr = (b_q != 32'd0);
                res_hi = rem_s;
                res_lo = quo_s;
            end
            OP_DIVU: begin
                res_wr = (b_q != 32'd0);
                res_hi = rem_u;
                res_lo = quo_u;
            end
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_md_op(op)) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        cnt   <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                    // Moves to HI/LO only land while idle; the pipeline stalls them otherwise.
                    if (op == OP_MTHI) begin
                        hi <= a;
                    end
                    if (op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Reads see committed HI/LO only; an in-flight result is not forwarded.
    always_comb begin
        out = 32'd0;
        if (op == OP_MFHI) begin
            out = hi;
        end else if (op == OP_MFLO) begin
            out = lo;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .out   (out),
        .hi    (hi),
        .lo    (lo)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference architectural HI/LO state.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one mult/div, using 64-bit arithmetic so no overflow cases arise.
    task automatic ref_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            4'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd1: begin p = ux * uy; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd2: if (y != 0) begin p = sx / sy; m_lo = p[31:0]; p = sx % sy; m_hi = p[31:0]; end
            4'd3: if (y != 0) begin p = ux / uy; m_lo = p[31:0]; p = ux % uy; m_hi = p[31:0]; end
            default: ;
        endcase
    endtask

    // Launch one mult/div and count busy cycles. Optionally inject an mthi at
    // run cycle 2, or keep a conflicting start asserted through the whole run.
    task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit inject_mthi, input bit hold_start);
        int          n;
        logic [31:0] hi_before;
        hi_before = m_hi;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NONE;
        n = 0;
        while (busy && n < 40) begin
            n++;
            a = $urandom; b = $urandom;
            op = OP_NONE; start = 1'b0;
            if (hold_start) begin
                start = 1'b1;
                op = 4'($urandom_range(0, 3));
            end
            if (inject_mthi && n == 2) begin
                op = OP_MTHI; a = 32'h0000_1234;
            end
            if (inject_mthi && n == 3) chk({tag, " hi held during run"}, hi, hi_before);
            @(posedge clk); #1;
        end
        start = 1'b0; op = OP_NONE;
        chk({tag, " busy cycles"}, 32'(n), (o >= 4'd2) ? 32'd10 : 32'd5);
        ref_md(o, x, y);
        chk({tag, " hi"}, hi, m_hi);
        chk({tag, " lo"}, lo, m_lo);
    endtask

    task automatic move_to(input logic [3:0] o, input logic [31:0] x);
        op = o; a = x;
        @(posedge clk); #1;
        op = OP_NONE;
        if (o == OP_MTHI) m_hi = x;
        else m_lo = x;
    endtask

    task automatic check_out(input string tag);
        op = OP_MFHI; #1;
        chk({tag, " mfhi"}, out, m_hi);
        op = OP_MFLO; #1;
        chk({tag, " mflo"}, out, m_lo);
        op = OP_NONE; #1;
        chk({tag, " out idle"}, out, 32'd0);
    endtask

    initial begin
        int          n;
        int          sel;
        logic [31:0] x;
        logic [31:0] y;

        rst_n = 1'b0; start = 1'b0; op = OP_MFHI; a = 32'hDEAD_BEEF; b = 32'h1;
        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset out", out, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; op = OP_NONE;
        @(posedge clk); #1;

        run_md("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("mult hi const", hi, 32'hFFFF_FFFF);
        chk("mult lo const", lo, 32'hFFFF_FFFE);
        run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("multu hi const", hi, 32'h0000_0001);
        chk("multu lo const", lo, 32'hFFFF_FFFE);
        run_md("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div lo const", lo, 32'hFFFF_FFFD);
        chk("div hi const", hi, 32'hFFFF_FFFF);
        run_md("divu", OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        chk("divu lo const", lo, 32'd3);
        chk("divu hi const", hi, 32'd1);

        move_to(OP_MTHI, 32'h11);
        move_to(OP_MTLO, 32'h22);
        check_out("preload");
        run_md("div0", OP_DIV, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        chk("div0 hi const", hi, 32'h11);
        chk("div0 lo const", lo, 32'h22);
        run_md("divu0", OP_DIVU, 32'h1234_5678, 32'd0, 1'b0, 1'b0);

        run_md("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div ovf lo const", lo, 32'h8000_0000);
        chk("div ovf hi const", hi, 32'd0);
        run_md("divu big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // mthi during a running mult is dropped; the product wins.
        run_md("mthi in run", OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        check_out("after mult");

        // A start held through the run, including the completion edge, is ignored.
        run_md("restart", OP_DIV, 32'hF000_0001, 32'd3, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("restart idle busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a divide.
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NONE;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (busy) n++;
        end
        chk("postrst busy", 32'(n), 32'd0);
        chk("postrst hi", hi, 32'd0);
        chk("postrst lo", lo, 32'd0);

        // Randomized mix against the reference model.
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if ($urandom_range(0, 1) == 1) y = -y;
            case (sel)
                0, 1, 2, 3: run_md("rand md", 4'(sel), x, y, 1'b0, 1'b0);
                4:          move_to(OP_MTHI, x);
                5:          move_to(OP_MTLO, x);
                6, 7:       check_out("rand");
                8: begin
                    start = 1'b1; op = 4'($urandom_range(8, 14)); a = x; b = y;
                    @(posedge clk); #1;
                    start = 1'b0; op = OP_NONE;
                    chk("bad op busy", {31'd0, busy}, 32'd0);
                end
                default: run_md("rand div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
            endcase
        end
        check_out("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
